// File: rtl/upstream_link_serializer.sv
// upstream_link_serializer: credit-gated serializer that splits core words into channel beats.
// One-entry input buffer feeds a beat shifter; io_token rising edges return credits.
module upstream_link_serializer #(
    parameter int DATA_WIDTH = 64,
    parameter int CHANNELS   = 2,
    parameter int CH_WIDTH   = 8,
    parameter int CREDITS    = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               core_valid_in,
    input  logic [DATA_WIDTH-1:0]              core_data_in,
    output logic                               core_ready_out,
    output logic                               io_valid_out,
    output logic [CHANNELS*CH_WIDTH-1:0]       io_data_out,
    input  logic                               io_token,
    output logic [$clog2(CREDITS+1)-1:0]       credits_avail,
    output logic [15:0]                        words_sent,
    output logic                               credit_err
);
    localparam int BW    = CHANNELS * CH_WIDTH;
    localparam int BEATS = DATA_WIDTH / BW;
    localparam int IW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int CW    = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);
    localparam logic [IW-1:0] LAST = IW'(BEATS - 1);

    generate
        if (BEATS < 1 || BEATS * BW != DATA_WIDTH) begin : g_bad_width
            $error("DATA_WIDTH must be a positive multiple of CHANNELS*CH_WIDTH");
        end
    endgenerate

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state, state_nx;
    logic [IW-1:0]         beat_idx, beat_nx;
    logic                  buf_valid, buf_nx;
    logic [DATA_WIDTH-1:0] buf_data, shift;
    logic                  tok_q;
    logic                  accept, at_last, load, ret;

    assign accept  = core_valid_in && core_ready_out;
    assign at_last = state == SEND && beat_idx == LAST;
    assign load    = buf_valid && credits_avail != '0 && (state == IDLE || at_last);
    assign ret     = io_token && !tok_q;
    assign buf_nx  = load ? 1'b0 : accept ? 1'b1 : buf_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_idx <= '0;
        end else begin
            state    <= state_nx;
            beat_idx <= beat_nx;
        end
    end

    always_comb begin
        state_nx = load ? SEND : at_last ? IDLE : state;
        beat_nx  = (load || at_last) ? '0 : state == SEND ? beat_idx + IW'(1) : beat_idx;
    end

    // ready is the registered complement of the next buffer state, so it never
    // depends combinationally on core_valid_in or io_token
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid      <= 1'b0;
            buf_data       <= '0;
            shift          <= '0;
            tok_q          <= 1'b0;
            credits_avail  <= CMAX;
            words_sent     <= '0;
            credit_err     <= 1'b0;
            core_ready_out <= 1'b0;
        end else begin
            tok_q          <= io_token;
            buf_valid      <= buf_nx;
            core_ready_out <= !buf_nx;
            if (accept)
                buf_data <= core_data_in;
            shift <= load ? buf_data : shift >> BW;
            if (at_last)
                words_sent <= words_sent + 16'd1;
            if (load && !ret)
                credits_avail <= credits_avail - CW'(1);
            else if (ret && !load && credits_avail == CMAX)
                credit_err <= 1'b1;
            else if (ret && !load)
                credits_avail <= credits_avail + CW'(1);
        end
    end

    assign io_valid_out = state == SEND;
    assign io_data_out  = io_valid_out ? shift[BW-1:0] : '0;
endmodule

// File: tb/tb_upstream_link_serializer.sv
// tb_upstream_link_serializer: randomized scoreboard bench for three serializer configurations.
module tb_upstream_link_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic v0 = 0, t0 = 0, r0, iv0, e0;
    logic [63:0] d0 = '0;
    logic [15:0] io0, ws0;
    logic [6:0]  c0;
    logic v1 = 0, t1 = 0, r1, iv1, e1;
    logic [63:0] d1 = '0;
    logic [15:0] io1, ws1;
    logic [1:0]  c1;
    logic v2 = 0, t2 = 0, r2, iv2, e2;
    logic [63:0] d2 = '0, io2;
    logic [15:0] ws2;
    logic [6:0]  c2;

    upstream_link_serializer u0 (
        .clk(clk), .rst(rst), .core_valid_in(v0), .core_data_in(d0), .core_ready_out(r0),
        .io_valid_out(iv0), .io_data_out(io0), .io_token(t0), .credits_avail(c0),
        .words_sent(ws0), .credit_err(e0));
    upstream_link_serializer #(.CREDITS(2)) u1 (
        .clk(clk), .rst(rst), .core_valid_in(v1), .core_data_in(d1), .core_ready_out(r1),
        .io_valid_out(iv1), .io_data_out(io1), .io_token(t1), .credits_avail(c1),
        .words_sent(ws1), .credit_err(e1));
    upstream_link_serializer #(.CHANNELS(4), .CH_WIDTH(16)) u2 (
        .clk(clk), .rst(rst), .core_valid_in(v2), .core_data_in(d2), .core_ready_out(r2),
        .io_valid_out(iv2), .io_data_out(io2), .io_token(t2), .credits_avail(c2),
        .words_sent(ws2), .credit_err(e2));

    int n_tests = 0, n_fail = 0;
    logic [63:0] q0[$], q1[$], q2[$];
    int run0 = 0, max0 = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference: each accepted word becomes its beats, low slice first
    always @(posedge clk) begin
        if (!rst) begin
            if (v0 && r0) for (int k = 0; k < 4; k++) q0.push_back(64'(d0[k*16 +: 16]));
            if (v1 && r1) for (int k = 0; k < 4; k++) q1.push_back(64'(d1[k*16 +: 16]));
            if (v2 && r2) q2.push_back(d2);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q0.delete(); q1.delete(); q2.delete();
            run0 = 0;
        end else begin
            if (iv0) begin
                chk("sb0_expected", 64'(q0.size() != 0), 64'd1);
                if (q0.size() != 0) chk("sb0_beat", 64'(io0), q0.pop_front());
                run0++;
                if (run0 > max0) max0 = run0;
            end else begin
                chk("sb0_idle_zero", 64'(io0), 64'd0);
                run0 = 0;
            end
            if (iv1) begin
                chk("sb1_expected", 64'(q1.size() != 0), 64'd1);
                if (q1.size() != 0) chk("sb1_beat", 64'(io1), q1.pop_front());
            end else chk("sb1_idle_zero", 64'(io1), 64'd0);
            if (iv2) begin
                chk("sb2_expected", 64'(q2.size() != 0), 64'd1);
                if (q2.size() != 0) chk("sb2_word", io2, q2.pop_front());
            end else chk("sb2_idle_zero", io2, 64'd0);
        end
    end

    function automatic logic rdy(input int u);
        return u == 0 ? r0 : u == 1 ? r1 : r2;
    endfunction

    task automatic set_in(input int u, input logic v, input logic [63:0] d);
        if (u == 0) begin v0 = v; d0 = d; end
        else if (u == 1) begin v1 = v; d1 = d; end
        else begin v2 = v; d2 = d; end
    endtask

    // call at a negedge; returns at the negedge after the accepting edge
    task automatic send(input int u, input logic [63:0] w, input bit keep);
        int b = 0;
        set_in(u, 1'b1, w);
        while (!rdy(u) && b < 200) begin @(negedge clk); b++; end
        if (b >= 200) chk("send_timeout", 64'(rdy(u)), 64'd1);
        @(negedge clk);
        if (!keep) set_in(u, 1'b0, {$urandom, $urandom});
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse0();
        t0 = 1'b1; @(negedge clk);
        t0 = 1'b0; @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] b34 [4] = '{16'h2211, 16'h4433, 16'h6655, 16'h8877};
        int cred0, nw, k, b, cnt;
        logic [63:0] w;
        @(negedge clk);
        chk("rst_ready", 64'(r0), 0);
        chk("rst_valid", 64'(iv0), 0);
        chk("rst_data", 64'(io0), 0);
        chk("rst_credits", 64'(c0), 64);
        chk("rst_words", 64'(ws0), 0);
        chk("rst_err", 64'(e0), 0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(r0), 1);

        send(0, 64'h8877665544332211, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t34_valid", 64'(iv0), 1);
            chk("t34_beat", 64'(io0), 64'(b34[i]));
        end
        @(negedge clk);
        chk("t34_end_valid", 64'(iv0), 0);
        chk("t34_words", 64'(ws0), 1);
        chk("t34_credits", 64'(c0), 63);

        do_reset();
        max0 = 0;
        for (int i = 0; i < 10; i++) send(0, {$urandom, $urandom}, i != 9);
        repeat (20) @(negedge clk);
        chk("t35_run", 64'(max0), 40);
        chk("t35_words", 64'(ws0), 10);
        chk("t35_credits", 64'(c0), 54);
        chk("t35_drained", 64'(q0.size()), 0);

        cred0 = 54;
        nw = $urandom_range(8, 20);
        for (int i = 0; i < nw; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(0, {$urandom, $urandom}, 0);
        end
        repeat (20) @(negedge clk);
        cred0 -= nw;
        chk("rnd_words", 64'(ws0), 64'(10 + nw));
        chk("rnd_credits", 64'(c0), 64'(cred0));
        k = $urandom_range(1, 64 - cred0);
        repeat (k) pulse0();
        cred0 += k;
        chk("rnd_returned", 64'(c0), 64'(cred0));
        chk("rnd_no_err", 64'(e0), 0);

        chk("t37_ready", 64'(r0), 1);
        v0 = 1'b1; d0 = {$urandom, $urandom};
        @(negedge clk);
        v0 = 1'b0; d0 = '0; t0 = 1'b1;
        @(negedge clk);
        t0 = 1'b0;
        chk("t37_load_and_token", 64'(c0), 64'(cred0));
        repeat (8) @(negedge clk);
        chk("t37_words", 64'(ws0), 64'(11 + nw));

        send(0, {$urandom, $urandom}, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t38_beat1_valid", 64'(iv0), 1);
        #2 rst = 1'b1;
        #1;
        chk("t38_valid_now", 64'(iv0), 0);
        chk("t38_data_now", 64'(io0), 0);
        chk("t38_ready_now", 64'(r0), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (iv0) cnt++;
        end
        chk("t38_no_residual", 64'(cnt), 0);
        chk("t38_credits", 64'(c0), 64);
        chk("t38_words", 64'(ws0), 0);
        chk("t38_ready", 64'(r0), 1);

        chk("t37_err_before", 64'(e0), 0);
        pulse0();
        chk("t37_err_set", 64'(e0), 1);
        chk("t37_saturate", 64'(c0), 64);
        pulse0();
        chk("t37_err_sticky", 64'(e0), 1);

        send(1, {$urandom, $urandom}, 1);
        send(1, {$urandom, $urandom}, 1);
        send(1, {$urandom, $urandom}, 0);
        repeat (20) @(negedge clk);
        chk("t36_held_ready", 64'(r1), 0);
        chk("t36_words", 64'(ws1), 2);
        chk("t36_credits", 64'(c1), 0);
        chk("t36_pending", 64'(q1.size()), 4);
        t1 = 1'b1;
        @(negedge clk);
        t1 = 1'b0;
        b = 0;
        while (!iv1 && b < 3) begin @(negedge clk); b++; end
        chk("t36_resume", 64'(iv1), 1);
        repeat (8) @(negedge clk);
        chk("t36_words_final", 64'(ws1), 3);
        chk("t36_credits_final", 64'(c1), 0);

        nw = $urandom_range(4, 10);
        for (int i = 0; i < nw; i++) begin
            w = {$urandom, $urandom};
            send(2, w, i != nw - 1);
        end
        repeat (8) @(negedge clk);
        chk("t39_words", 64'(ws2), 64'(nw));
        chk("t39_credits", 64'(c2), 64'(64 - nw));
        chk("t39_drained", 64'(q2.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
